// File: rtl/CPU_package.sv
// Shared CPU definitions: datapath width, ALU opcode/flag types, and the
// scheduler state type used by alu_scheduler.
package CPU_package;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SBC = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_NOT = 3'd7
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } struct_alu_flag_t;

    localparam int OPC_W  = $bits(enum_alu_opcode_t);
    localparam int FLAG_W = $bits(struct_alu_flag_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for alu_scheduler: round-robin by default, fixed lowest-index
// priority when ALU_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;

`ifdef ALU_SCHED_FIXED_PRIO_EN

    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, advance};

    // Scan downwards so the lowest requesting index is the last one written.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_id) : '0;
    end

`else

    logic [ID_W-1:0] last_grant;
    int              idx;

    // The search starts one past the previous winner and wraps, so the
    // previous winner itself is considered last.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_id) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_grant <= grant_id;
        end
    end

`endif

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU between NUM_REQ requesters with a tagged response.
// Arbitration policy is selected by ALU_SCHED_FIXED_PRIO_EN inside rr_arbiter.
module alu_scheduler
    import CPU_package::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_carry,
    input  logic [NUM_REQ*OPC_W-1:0]      req_opcode,
    input  logic [NUM_REQ-1:0]            req_mode,
    output logic [DATA_WIDTH-1:0]         alu_in_a,
    output logic [DATA_WIDTH-1:0]         alu_in_b,
    output logic                          alu_input_carry,
    output logic [OPC_W-1:0]              alu_opcode,
    output logic                          alu_mode,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    input  logic [FLAG_W-1:0]             alu_out_flag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [FLAG_W-1:0]             rsp_flag
);

    sched_state_t        state, next_state;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grants are only offered in IDLE and never while reset is asserted.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready  = grant;
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in_a        <= '0;
            alu_in_b        <= '0;
            alu_input_carry <= 1'b0;
            alu_opcode      <= '0;
            alu_mode        <= 1'b0;
            rsp_id          <= '0;
            rsp_data        <= '0;
            rsp_flag        <= '0;
        end else begin
            if (accept) begin
                alu_in_a        <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                alu_in_b        <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
                alu_input_carry <= req_carry[grant_id];
                alu_opcode      <= req_opcode[grant_id*OPC_W +: OPC_W];
                alu_mode        <= req_mode[grant_id];
                rsp_id          <= grant_id;
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_flag <= alu_out_flag;
            end
        end
    end

endmodule
